// File: rtl/led_pkg.sv
// Shared types, defaults and the per-channel brightness scaler for the LED strip sequencer.
package led_pkg;

    localparam int unsigned LED_NUM_LEDS_DEF     = 8;
    localparam int unsigned LED_LATCH_CYCLES_DEF = 1440;

    typedef logic [23:0] pixel_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPTURE,
        ST_SEND,
        ST_LATCH
    } led_state_e;

    function automatic int unsigned led_addr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // (ch * (b + 1)) >> 8: b = 255 is identity, b = 0 always yields 0.
    function automatic logic [7:0] led_scale_ch(input logic [7:0] ch, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'(ch) * (16'(b) + 16'd1);
        return prod[15:8];
    endfunction

    function automatic pixel_t led_scale_px(input pixel_t px, input logic [7:0] b);
        return {led_scale_ch(px[23:16], b), led_scale_ch(px[15:8], b), led_scale_ch(px[7:0], b)};
    endfunction

endpackage

// File: rtl/led_latch_timer.sv
// Counts cycles spent in the latch gap; expired marks the last cycle of the gap.
module led_latch_timer
#(
    parameter int unsigned LATCH_CYCLES = 1440
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic expired
);

    localparam int unsigned    CW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [CW-1:0]  TC = CW'(LATCH_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Saturates at the terminal count so a late exit can never wrap the gap.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q != TC) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == TC);

endmodule

// File: rtl/led_strip_sequencer.sv
// Walks pixel memory once per frame, scales each pixel by a per-frame brightness and
// hands it to the strip driver, then holds a latch gap before the next frame.
module led_strip_sequencer
    import led_pkg::*;
#(
    parameter int unsigned NUM_LEDS     = LED_NUM_LEDS_DEF,
    parameter int unsigned LATCH_CYCLES = LED_LATCH_CYCLES_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            auto_run,
    input  logic [7:0]                      bright,
    output logic [led_addr_w(NUM_LEDS)-1:0] pix_addr,
    input  pixel_t                          pix_data,
    output pixel_t                          rgb,
    output logic                            load,
    input  logic                            drv_done,
    output logic                            busy,
    output logic                            frame_done
);

    localparam int unsigned   AW   = led_addr_w(NUM_LEDS);
    localparam logic [AW-1:0] LAST = AW'(NUM_LEDS - 1);

    led_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    bright_q, bright_d;
    pixel_t        rgb_q, rgb_d;
    logic          pend_q, pend_d;
    logic          begin_frame;
    logic          latch_clear;
    logic          latch_expired;

    led_latch_timer #(
        .LATCH_CYCLES(LATCH_CYCLES)
    ) u_latch_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (latch_clear),
        .expired (latch_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        begin_frame = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start || auto_run) begin
                    state_d     = ST_FETCH;
                    begin_frame = 1'b1;
                end
            end
            ST_FETCH:   state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_SEND;
            ST_SEND: begin
                if (drv_done) begin
                    state_d = (addr_q == LAST) ? ST_LATCH : ST_FETCH;
                end
            end
            // A start landing in the final gap cycle begins the next frame directly.
            ST_LATCH: begin
                if (latch_expired) begin
                    if (auto_run || pend_q || start) begin
                        state_d     = ST_FETCH;
                        begin_frame = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load        = (state_q == ST_SEND);
        busy        = (state_q != ST_IDLE);
        frame_done  = (state_q == ST_LATCH) && latch_expired;
        latch_clear = (state_q != ST_LATCH);
    end

    always_comb begin
        addr_d   = addr_q;
        bright_d = bright_q;
        rgb_d    = rgb_q;
        pend_d   = pend_q;
        if (begin_frame) begin
            addr_d   = '0;
            bright_d = bright;
            pend_d   = 1'b0;
        end else begin
            if (start && busy) begin
                pend_d = 1'b1;
            end
            if ((state_q == ST_SEND) && drv_done && (addr_q != LAST)) begin
                addr_d = addr_q + AW'(1);
            end
        end
        if (state_q == ST_CAPTURE) begin
            rgb_d = led_scale_px(pix_data, bright_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= '0;
            bright_q <= '0;
            rgb_q    <= '0;
            pend_q   <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            bright_q <= bright_d;
            rgb_q    <= rgb_d;
            pend_q   <= pend_d;
        end
    end

    assign pix_addr = addr_q;
    assign rgb      = rgb_q;

endmodule

// File: tb/tb_led_strip_sequencer.sv
// Bench for led_strip_sequencer: a cycle-timeline model checked every cycle plus directed scenarios.
module tb_led_strip_sequencer;
    import led_pkg::*;

    localparam int unsigned N = 3;
    localparam int unsigned L = 20;

    logic       clk = 1'b0, rst = 1'b0, start = 1'b0, auto_run = 1'b0, drv_done = 1'b0;
    logic [7:0] bright = 8'd0;
    logic [1:0] pix_addr;
    pixel_t     pix_data = '0, rgb;
    logic       load, busy, frame_done;

    logic       start1 = 1'b0, auto_run1 = 1'b0, drv_done1 = 1'b0;
    logic [7:0] bright1 = 8'd255;
    logic [0:0] pix_addr1;
    pixel_t     pix_data1 = '0, rgb1;
    logic       load1, busy1, frame_done1;

    pixel_t mem [N];
    pixel_t mem1 = 24'h123456;

    led_strip_sequencer #(.NUM_LEDS(N), .LATCH_CYCLES(L)) u_dut (
        .clk(clk), .rst(rst), .start(start), .auto_run(auto_run), .bright(bright),
        .pix_addr(pix_addr), .pix_data(pix_data), .rgb(rgb), .load(load),
        .drv_done(drv_done), .busy(busy), .frame_done(frame_done)
    );

    led_strip_sequencer #(.NUM_LEDS(1), .LATCH_CYCLES(L)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .auto_run(auto_run1), .bright(bright1),
        .pix_addr(pix_addr1), .pix_data(pix_data1), .rgb(rgb1), .load(load1),
        .drv_done(drv_done1), .busy(busy1), .frame_done(frame_done1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pix_data  <= mem[pix_addr];
    always @(posedge clk) pix_data1 <= mem1;

    int unsigned n_checks = 0, n_fail = 0, cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic pixel_t ref_scale(input pixel_t p, input int unsigned b);
        int unsigned g, r, bl;
        g  = (int'(p[23:16]) * (b + 1)) / 256;
        r  = (int'(p[15:8])  * (b + 1)) / 256;
        bl = (int'(p[7:0])   * (b + 1)) / 256;
        return {8'(g), 8'(r), 8'(bl)};
    endfunction

    // Driver stand-in: drv_done arrives drv_delay cycles after load rises.
    int unsigned drv_delay = 3, dcnt = 0, dd_n = 0;
    int unsigned dd_cyc [64];
    bit          spurious_en = 0;
    always @(negedge clk) begin
        drv_done = 1'b0;
        if (rst && load) begin
            if (dcnt >= drv_delay) begin
                drv_done = 1'b1;
                dcnt     = 0;
                if (dd_n < 64) dd_cyc[dd_n] = cyc;
                dd_n++;
            end else begin
                dcnt++;
            end
        end else begin
            dcnt = 0;
            if (spurious_en && $urandom_range(0, 7) == 0) drv_done = 1'b1;
        end
    end

    int unsigned lr_n = 0, fd_n = 0, fd_cyc = 0, l1_n = 0;
    pixel_t      lr_rgb  [64];
    int unsigned lr_addr [64];
    int unsigned lr_cyc  [64];
    logic        load_prev = 1'b0, load1_prev = 1'b0;
    always @(negedge clk) begin
        if (load && !load_prev && lr_n < 64) begin
            lr_rgb[lr_n]  = rgb;
            lr_addr[lr_n] = 32'(pix_addr);
            lr_cyc[lr_n]  = cyc;
            lr_n++;
        end
        if (frame_done) begin
            fd_n++;
            fd_cyc = cyc;
        end
        if (load1 && !load1_prev) l1_n++;
        load_prev  = load;
        load1_prev = load1;
    end

    task automatic clear_logs();
        lr_n = 0; fd_n = 0; dd_n = 0;
    endtask

    // Model timeline: m_wait counts down to the load cycle, m_gap counts down the latch gap.
    bit          m_busy = 0, m_pend = 0;
    int unsigned m_pix = 0, m_wait = 0, m_gap = 0, m_bright = 0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 0; m_pend = 0; m_pix = 0; m_wait = 0; m_gap = 0; m_bright = 0;
        end else begin
            bit fb, was_busy;
            fb = 0;
            was_busy = m_busy;
            if (!m_busy) begin
                if (start || auto_run) fb = 1;
            end else if (m_gap != 0) begin
                if (m_gap == 1) begin
                    if (auto_run || m_pend || start) fb = 1;
                    else begin m_busy = 0; m_gap = 0; end
                end else begin
                    m_gap--;
                end
            end else if (m_wait != 0) begin
                m_wait--;
            end else if (drv_done) begin
                if (m_pix == N - 1) m_gap = L;
                else begin m_pix++; m_wait = 2; end
            end
            if (fb) begin
                m_busy = 1; m_pix = 0; m_bright = bright; m_wait = 2; m_gap = 0; m_pend = 0;
            end else if (was_busy && start) begin
                m_pend = 1;
            end
        end
    end

    always @(negedge clk) begin
        bit e_load;
        e_load = m_busy && (m_gap == 0) && (m_wait == 0);
        check("busy", 32'(busy), 32'(m_busy));
        check("load", 32'(load), 32'(e_load));
        check("pix_addr", 32'(pix_addr), m_pix);
        check("frame_done", 32'(frame_done), 32'(m_busy && m_gap == 1));
        if (e_load) check("rgb", 32'(rgb), 32'(ref_scale(mem[m_pix], m_bright)));
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned max, input string name);
        int unsigned k = 0;
        while (busy && k < max) begin @(negedge clk); k++; end
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic wait_load(input int unsigned max, input string name);
        int unsigned k = 0;
        while (!load && k < max) begin @(negedge clk); k++; end
        check(name, 32'(load), 32'd1);
    endtask

    initial begin
        mem[0] = 24'hFF0000; mem[1] = 24'h00FF00; mem[2] = 24'h0000FF;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_load", 32'(load), 32'd0);
        check("rst_addr", 32'(pix_addr), 32'd0);
        check("rst_rgb", 32'(rgb), 32'd0);
        check("rst_fdone", 32'(frame_done), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        @(negedge clk) rst = 1'b1;

        // Full-brightness frame with a slow driver.
        bright = 8'd255; drv_delay = 30;
        clear_logs();
        pulse_start();
        wait_idle(1000, "t40_idle");
        check("t40_loads", lr_n, 32'd3);
        check("t40_rgb0", 32'(lr_rgb[0]), 32'hFF0000);
        check("t40_rgb1", 32'(lr_rgb[1]), 32'h00FF00);
        check("t40_rgb2", 32'(lr_rgb[2]), 32'h0000FF);
        check("t40_fdone_n", fd_n, 32'd1);
        check("t40_gap", fd_cyc - dd_cyc[2], L);

        // Scaled pixel; brightness changes mid-frame must not apply.
        mem[0] = 24'h80FF40; bright = 8'd127; drv_delay = 2;
        clear_logs();
        pulse_start();
        bright = 8'd3;
        wait_idle(500, "t41_idle");
        check("t41_rgb0", 32'(lr_rgb[0]), 32'h407F20);
        check("t41_rgb1", 32'(lr_rgb[1]), 32'h007F00);

        // Two back-to-back auto-run frames.
        clear_logs();
        @(negedge clk) auto_run = 1'b1;
        begin
            int unsigned k = 0;
            while (lr_n < 4 && k < 500) begin @(negedge clk); k++; end
        end
        auto_run = 1'b0;
        wait_idle(500, "t42_idle");
        check("t42_loads", lr_n, 32'd6);
        check("t42_frames", fd_n, 32'd2);
        check("t42_restart", lr_addr[3], 32'd0);
        check("t42_gap", lr_cyc[3] - dd_cyc[2], L + 3);

        // Two starts while sending give exactly one extra frame.
        drv_delay = 10;
        clear_logs();
        pulse_start();
        wait_load(10, "t43_load");
        pulse_start();
        pulse_start();
        wait_idle(1000, "t43_idle");
        check("t43_frames", fd_n, 32'd2);
        check("t43_loads", lr_n, 32'd6);

        // Asynchronous reset in the middle of SEND.
        clear_logs();
        pulse_start();
        wait_load(10, "t44_load");
        @(negedge clk);
        #1 rst = 1'b0;
        #1 check("t44_load_async", 32'(load), 32'd0);
        check("t44_busy_async", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clear_logs();
        pulse_start();
        wait_idle(500, "t44_idle");
        check("t44_loads", lr_n, 32'd3);
        check("t44_addr0", lr_addr[0], 32'd0);
        check("t44_addr2", lr_addr[2], 32'd2);

        // Single-pixel strip with a spurious drv_done while idle.
        @(negedge clk) drv_done1 = 1'b1;
        @(negedge clk) drv_done1 = 1'b0;
        check("t45_idle_busy", 32'(busy1), 32'd0);
        check("t45_idle_load", 32'(load1), 32'd0);
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        begin
            int unsigned k = 0;
            while (!load1 && k < 10) begin @(negedge clk); k++; end
            check("t45_load", 32'(load1), 32'd1);
            check("t45_rgb", 32'(rgb1), 32'h123456);
            check("t45_addr", 32'(pix_addr1), 32'd0);
            drv_done1 = 1'b1;
            k = 0;
            do begin
                @(negedge clk);
                k++;
                if (k == 1) begin
                    drv_done1 = 1'b0;
                    check("t45_latch_load", 32'(load1), 32'd0);
                    check("t45_latch_busy", 32'(busy1), 32'd1);
                end
            end while (!frame_done1 && k < 100);
            check("t45_gap", k, L);
            @(negedge clk);
            check("t45_end_idle", 32'(busy1), 32'd0);
            check("t45_pulses", l1_n, 32'd1);
        end

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < N; i++) mem[i] = 24'($urandom);
        spurious_en = 1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start  = ($urandom_range(0, 9) == 0);
            bright = 8'($urandom);
            if ($urandom_range(0, 199) == 0) auto_run = ~auto_run;
            if ($urandom_range(0, 49) == 0) drv_delay = $urandom_range(0, 6);
        end
        start = 1'b0; auto_run = 1'b0;
        wait_idle(2000, "rand_idle");
        spurious_en = 0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
